// File: rtl/ppu_interrupt_ctrl.sv
// rtl/ppu_interrupt_ctrl.sv - PPU video-timing interrupt controller with per-source edge latches
//
// Synchronises NUM_SRC asynchronous timing inputs, detects edges per source
// under a 2-bit mode, and latches events into pending/overflow bits plus a
// saturating event counter. irq_o is the OR of pending; irq_pulse_o marks the
// first cycle irq_o goes high.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   src_i        raw asynchronous timing inputs
//   mode_i       per source [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clear_i      per-source clear of pending/overflow/count (level)
//   clear_all_i  clear every source
//   pending_o    latched event per source
//   overflow_o   event arrived while already pending
//   count_o      saturating event counters, source i at [i*CNT_WIDTH +: CNT_WIDTH]
//   irq_o        OR of pending_o
//   irq_pulse_o  high on the first cycle irq_o is high
module ppu_interrupt_ctrl #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 CNT_WIDTH   = 8,
    parameter logic [NUM_SRC-1:0] SRC_INIT    = 4'b1100
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_i,
    input  logic [2*NUM_SRC-1:0]           mode_i,
    input  logic [NUM_SRC-1:0]             clear_i,
    input  logic                           clear_all_i,
    output logic [NUM_SRC-1:0]             pending_o,
    output logic [NUM_SRC-1:0]             overflow_o,
    output logic [NUM_SRC*CNT_WIDTH-1:0]   count_o,
    output logic                           irq_o,
    output logic                           irq_pulse_o
);

    // sync_q[0] is the first flop after the pin; sync_q[SYNC_STAGES-1] is the
    // synchronised value used for edge detection.
    logic [NUM_SRC-1:0]           sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0]           sync_d [SYNC_STAGES];
    logic [NUM_SRC-1:0]           prev_q, prev_d;
    logic [NUM_SRC-1:0]           pending_q, pending_d;
    logic [NUM_SRC-1:0]           overflow_q, overflow_d;
    logic [NUM_SRC*CNT_WIDTH-1:0] count_q, count_d;
    logic                         irq_q, irq_d;

    logic [NUM_SRC-1:0]           rise, fall, evt, clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= SRC_INIT;
            end
            prev_q     <= SRC_INIT;
            pending_q  <= '0;
            overflow_q <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        sync_d[0] = src_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        rise = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall = ~sync_q[SYNC_STAGES-1] & prev_q;
        evt  = '0;
        clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            evt[i] = (mode_i[2*i] & rise[i]) | (mode_i[2*i+1] & fall[i]);
            clr[i] = clear_i[i] | clear_all_i;
        end
    end

    // Set dominates clear so an event coinciding with a clear is never lost.
    always_comb begin
        pending_d  = evt | (pending_q & ~clr);
        overflow_d = (evt & pending_q & ~clr) | (overflow_q & ~clr);
        count_d    = count_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (clr[i]) begin
                count_d[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(evt[i]);
            end else if (count_q[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}}) begin
                count_d[i*CNT_WIDTH +: CNT_WIDTH] =
                    count_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(evt[i]);
            end
        end
        irq_d = irq_o;
    end

    always_comb begin
        pending_o   = pending_q;
        overflow_o  = overflow_q;
        count_o     = count_q;
        irq_o       = |pending_q;
        irq_pulse_o = irq_o & ~irq_q;
    end

endmodule

// File: doc/ppu_interrupt_ctrl.md
Name: ppu_interrupt_ctrl

Overview:
Parametrised PPU video-timing interrupt controller, successor to the fixed 4-signal edge latch. It synchronises NUM_SRC asynchronous timing inputs (vblank, hblank, csync_n, burst_n, ...) and detects edges per source with a programmable mode. Events latch into per-source pending bits, with overflow flags and saturating event counters. A single level IRQ and a one-cycle IRQ strobe feed the host-side register/USB bridge.

Parameters:
NUM_SRC, 4, number of timing sources
SYNC_STAGES, 2, synchroniser flops per source (min 2)
CNT_WIDTH, 8, width of each per-source event counter
SRC_INIT, 4'b1100, per-source idle level loaded into synchroniser and history flops at reset (bit i = source i)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
src_i  in  NUM_SRC  raw asynchronous timing inputs
mode_i  in  2*NUM_SRC  per source [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both edges
clear_i  in  NUM_SRC  per-source clear of pending/overflow/count (level, acts every cycle high)
clear_all_i  in  1  clear all sources
pending_o  out  NUM_SRC  latched event per source
overflow_o  out  NUM_SRC  event arrived while source already pending
count_o  out  NUM_SRC*CNT_WIDTH  saturating events since last clear, source i at [i*CNT_WIDTH +: CNT_WIDTH]
irq_o  out  1  OR of pending_o
irq_pulse_o  out  1  high for exactly the first cycle irq_o is high

Behaviour:
- Reset (async, immediate): sync chain and history flops = SRC_INIT[i]; pending, overflow, count, irq history = 0. All outputs 0 while reset is high, mid-operation included.
- After reset release, an input that differs from SRC_INIT produces a real edge, detected normally.
- Per source: s[0] <= src_i, s[k] <= s[k-1], prev <= s[SYNC_STAGES-1].
- Edge detection uses only synchronised values: rise = s_last & ~prev, fall = ~s_last & prev.
- event_i = (mode bit0 & rise) | (mode bit1 & fall). Mode 00 produces no events and leaves pending unchanged.
- Latency: src_i changes before clock edge 1; pending_o is high after edge SYNC_STAGES+1 (3 with default). Pulses shorter than one clock may be missed; that is by design.
- clr_i = clear_i[i] | clear_all_i.
- pending next = event_i | (pending & ~clr_i). Set dominates clear, so no event is lost on a same-cycle clear.
- overflow next = (event_i & pending & ~clr_i) | (overflow & ~clr_i).
- count next:
  - clr_i: 0 + event_i.
  - otherwise: count + event_i, holding at all-ones (no wrap).
- Mode changes take effect on the next edge evaluation. A mode change never alters pending, overflow or count.
- irq_o = |pending_o. This is purely from registers, so it is glitch-free.
- irq_q <= irq_o; irq_pulse_o = irq_o & ~irq_q. An event on another source while irq_o is already high produces no new pulse.
- A clear and a new event in the same cycle on the same source: pending stays 1, overflow = 0, count = 1, irq_o stays high, no pulse.
- Sources are fully independent: simultaneous events on any subset all latch in the same cycle.

Test Plan:
- Reset, src_i held at SRC_INIT, all modes 11 for 100 cycles -> pending_o = 0, irq_o = 0, all counts 0.
- Source 0 mode 01, src_i[0] 0->1 before edge 1 -> pending_o[0] = 1 after edge 3, irq_pulse_o high for that one cycle only, count0 = 1; the following 1->0 fall adds nothing.
- Source 2 mode 11, five toggles without clear -> count2 = 5, overflow_o[2] = 1; then clear_i[2] for one cycle -> pending, overflow, count2 all 0.
- CNT_WIDTH = 2, 6 rising events on source 1 -> count1 saturates at 3 (no wrap).
- clear_all_i asserted in the same cycle as a detected event on source 3 -> pending_o[3] = 1, count3 = 1, overflow_o[3] = 0; all other sources cleared.
- Reset asserted mid-stream with pending = 4'b1011 -> all outputs 0 asynchronously without a clock edge; after release with src_i = SRC_INIT, no events.
